// File: rtl/usb3_phy_init_pkg.sv
// rtl/usb3_phy_init_pkg.sv - state encoding, default timing constants and counter width helper
package usb3_phy_init_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_RST_ASSERT = 3'd0;
  localparam state_t ST_STRAP_HOLD = 3'd1;
  localparam state_t ST_WAIT_LOCK  = 3'd2;
  localparam state_t ST_RUN        = 3'd3;
  localparam state_t ST_FAULT      = 3'd4;

  localparam int unsigned DEF_RESET_CYCLES       = 64;
  localparam int unsigned DEF_STRAP_HOLD_CYCLES  = 16;
  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 32;
  localparam int unsigned DEF_LOCK_TIMEOUT       = 65535;
  localparam int unsigned DEF_RETRY_MAX          = 3;

  // One bit beyond what the largest terminal count needs.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/usb3_sync2.sv
// rtl/usb3_sync2.sv - two-flop synchroniser, clears to 0 on reset
module usb3_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/usb3_phy_init_seq.sv
// rtl/usb3_phy_init_seq.sv - USB3 PHY reset/strap/lock bring-up sequencer
module usb3_phy_init_seq
  import usb3_phy_init_pkg::*;
#(
  parameter int unsigned RESET_CYCLES       = DEF_RESET_CYCLES,
  parameter int unsigned STRAP_HOLD_CYCLES  = DEF_STRAP_HOLD_CYCLES,
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned LOCK_TIMEOUT       = DEF_LOCK_TIMEOUT,
  parameter int unsigned RETRY_MAX          = DEF_RETRY_MAX
) (
  input  logic       ext_clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       phy_pwrpresent,
  input  logic       restart,
  output logic       phy_reset_n,
  output logic       strap_oe,
  output logic       core_ready,
  output logic       fault,
  output logic [1:0] attempt
);

  localparam int unsigned CW = cnt_width(RESET_CYCLES, STRAP_HOLD_CYCLES,
                                         LOCK_STABLE_CYCLES, LOCK_TIMEOUT);

  // Terminal values are "last cycle of the phase", so each phase lasts exactly N cycles.
  localparam logic [CW-1:0] RST_TC   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] STRAP_TC = CW'(STRAP_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAB_TC  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_TC    = CW'(LOCK_TIMEOUT - 1);

  logic lock_s;
  logic pwr_s;
  logic both_high;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stab_q, stab_d;
  logic [1:0]    fail_cnt_q, fail_cnt_d;
  logic          retries_spent;

  logic       phy_reset_n_q, phy_reset_n_d;
  logic       strap_oe_q, strap_oe_d;
  logic       core_ready_q, core_ready_d;
  logic       fault_q, fault_d;
  logic [1:0] attempt_q, attempt_d;

  usb3_sync2 u_sync_lock (
    .clk (ext_clk),
    .rst (reset),
    .d   (pll_locked),
    .q   (lock_s)
  );

  usb3_sync2 u_sync_pwr (
    .clk (ext_clk),
    .rst (reset),
    .d   (phy_pwrpresent),
    .q   (pwr_s)
  );

  assign both_high     = lock_s & pwr_s;
  assign retries_spent = (32'(fail_cnt_q) + 32'd1) >= RETRY_MAX;

  // Next-state, phase/timeout counter, stability counter and failed-attempt count.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stab_d     = '0;
    fail_cnt_d = fail_cnt_q;
    case (state_q)
      ST_RST_ASSERT: begin
        if (restart) begin
          cnt_d = '0;
        end else if (cnt_q >= RST_TC) begin
          state_d = ST_STRAP_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STRAP_HOLD: begin
        if (restart) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = '0;
        end else if (cnt_q >= STRAP_TC) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // Restart beats lock-done, which beats timeout.
        if (restart) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = '0;
        end else if (both_high && (stab_q >= STAB_TC)) begin
          state_d    = ST_RUN;
          cnt_d      = '0;
          fail_cnt_d = '0;
        end else if (cnt_q >= TO_TC) begin
          state_d    = retries_spent ? ST_FAULT : ST_RST_ASSERT;
          cnt_d      = '0;
          fail_cnt_d = fail_cnt_q + 2'd1;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          stab_d = both_high ? stab_q + 1'b1 : '0;
        end
      end
      ST_RUN: begin
        // Loss of lock/VBUS is not a failed attempt; the retry budget is untouched.
        if (restart || !both_high) begin
          state_d = ST_RST_ASSERT;
          cnt_d   = '0;
        end
      end
      ST_FAULT: begin
        if (restart) begin
          state_d    = ST_RST_ASSERT;
          cnt_d      = '0;
          fail_cnt_d = '0;
        end
      end
      default: begin
        state_d = ST_RST_ASSERT;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the current state; registered below so pins never glitch.
  always_comb begin
    phy_reset_n_d = 1'b0;
    strap_oe_d    = 1'b1;
    core_ready_d  = 1'b0;
    fault_d       = 1'b0;
    attempt_d     = fail_cnt_q;
    case (state_q)
      ST_STRAP_HOLD: phy_reset_n_d = 1'b1;
      ST_WAIT_LOCK: begin
        phy_reset_n_d = 1'b1;
        strap_oe_d    = 1'b0;
      end
      ST_RUN: begin
        phy_reset_n_d = 1'b1;
        strap_oe_d    = 1'b0;
        core_ready_d  = 1'b1;
      end
      ST_FAULT: fault_d = 1'b1;
      default: ;
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge ext_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_RST_ASSERT;
      cnt_q         <= '0;
      stab_q        <= '0;
      fail_cnt_q    <= '0;
      phy_reset_n_q <= 1'b0;
      strap_oe_q    <= 1'b1;
      core_ready_q  <= 1'b0;
      fault_q       <= 1'b0;
      attempt_q     <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stab_q        <= stab_d;
      fail_cnt_q    <= fail_cnt_d;
      phy_reset_n_q <= phy_reset_n_d;
      strap_oe_q    <= strap_oe_d;
      core_ready_q  <= core_ready_d;
      fault_q       <= fault_d;
      attempt_q     <= attempt_d;
    end
  end

  assign phy_reset_n = phy_reset_n_q;
  assign strap_oe    = strap_oe_q;
  assign core_ready  = core_ready_q;
  assign fault       = fault_q;
  assign attempt     = attempt_q;

endmodule
